// File: rtl/stream_mux_nto1_if.sv
// -----------------------------------------------------------------------------
// stream_mux_nto1_if
// Bundle of all non-clock signals of the N:1 packet-stream multiplexer.
//   mode      : 0 = fixed select, 1 = round-robin arbitration
//   sel       : channel index used in fixed-select mode
//   in_data   : N packed channels, channel c at [c*W +: W]
//   in_valid  : per-channel valid
//   in_last   : per-channel end-of-packet flag
//   in_ready  : per-channel ready (only the locked channel can be ready)
//   out_data  : registered output beat
//   out_valid : registered output valid
//   out_last  : registered output end-of-packet flag
//   out_ready : downstream ready
//   grant     : currently locked or last-locked channel
//   pkt_cnt   : completed-packet counter (zero unless the counter is built in)
// Modports:
//   master : packet sources plus downstream consumer (drives the inputs)
//   slave  : the multiplexer itself
// -----------------------------------------------------------------------------
interface stream_mux_nto1_if #(
    parameter int SEL_W = 2,
    parameter int W     = 8
);
    localparam int N = 1 << SEL_W;

    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [N*W-1:0]       in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_last;
    logic [N-1:0]         in_ready;
    logic [W-1:0]         out_data;
    logic                 out_valid;
    logic                 out_last;
    logic                 out_ready;
    logic [SEL_W-1:0]     grant;
    logic [15:0]          pkt_cnt;

    modport master (
        output mode, sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, grant, pkt_cnt
    );

    modport slave (
        input  mode, sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, grant, pkt_cnt
    );
endinterface

// File: rtl/stream_mux_nto1.sv
// -----------------------------------------------------------------------------
// stream_mux_nto1
// N:1 packet-stream multiplexer (N = 2**SEL_W) with a one-entry registered
// output stage. A channel is picked in IDLE either by the external select or by
// round-robin search, then stays locked until its last beat is accepted.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : stream_mux_nto1_if.slave, all handshake/data/status signals
// Optional feature:
//   STREAM_MUX_PKTCNT_EN : when defined, pkt_cnt counts output beats that carry
//                          last (16-bit, wrapping). When undefined pkt_cnt is 0.
// -----------------------------------------------------------------------------
module stream_mux_nto1 #(
    parameter int SEL_W = 2,
    parameter int W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    stream_mux_nto1_if.slave    bus
);
    localparam int N = 1 << SEL_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [W-1:0]     out_data_q, out_data_d;

    logic [N-1:0]     in_ready_s;
    logic             out_free_s;
    logic             accept_s;
    logic [W-1:0]     grant_data_s;
    logic             grant_last_s;
    logic [SEL_W:0]   rr_result_s;

    // Search ptr+1 .. ptr+N (mod N); MSB of the result flags a hit.
    function automatic logic [SEL_W:0] rr_search(input logic [SEL_W-1:0] ptr,
                                                 input logic [N-1:0]     valid);
        logic [SEL_W-1:0] cand;
        logic [SEL_W-1:0] pick;
        logic             found;
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= N; i++) begin
            cand  = ptr + SEL_W'(i);
            pick  = (!found && valid[cand]) ? cand : pick;
            found = found | valid[cand];
        end
        return {found, pick};
    endfunction

    assign out_free_s   = !out_valid_q || bus.out_ready;
    assign grant_data_s = bus.in_data[int'(grant_q)*W +: W];
    assign grant_last_s = bus.in_last[grant_q];
    assign accept_s     = bus.in_valid[grant_q] && in_ready_s[grant_q];
    assign rr_result_s  = rr_search(ptr_q, bus.in_valid);

    // Ready is offered only to the locked channel, and only if the output slot frees up.
    always_comb begin
        in_ready_s = '0;
        for (int c = 0; c < N; c++) begin
            in_ready_s[c] = (state_q == ST_BUSY) && (SEL_W'(c) == grant_q) && out_free_s;
        end
    end

    // Arbitration / lock FSM next-state logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.mode == 1'b0) begin
                    if (bus.in_valid[bus.sel]) begin
                        grant_d = bus.sel;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (rr_result_s[SEL_W]) begin
                        grant_d = rr_result_s[SEL_W-1:0];
                        ptr_d   = rr_result_s[SEL_W-1:0];
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BUSY: begin
                if (accept_s && grant_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register: load on an accepted beat, otherwise drop valid once drained.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data_s;
            out_last_d  = grant_last_s;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State, grant, pointer and output-stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= SEL_W'(N - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef STREAM_MUX_PKTCNT_EN
    logic [15:0] pkt_cnt_q;

    // Completed-packet counter, advanced when a last beat leaves the output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q <= 16'd0;
        end else if (out_valid_q && bus.out_ready && out_last_q) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end else begin
            pkt_cnt_q <= pkt_cnt_q;
        end
    end

    assign bus.pkt_cnt = pkt_cnt_q;
`else
    assign bus.pkt_cnt = 16'd0;
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.grant     = grant_q;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_nto1
// Directed bench for stream_mux_nto1 (SEL_W=2, W=8). Every beat the bench
// offers is pushed to a scoreboard queue; each output transfer pops and
// compares. Directed checks cover reset, grant order, backpressure, lock and
// asynchronous reset behaviour.
// -----------------------------------------------------------------------------
module tb_stream_mux_nto1;
    localparam int SEL_W = 2;
    localparam int W     = 8;
    localparam int N     = 1 << SEL_W;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   pk_sent;
    logic [8:0] sb_q[$];
    logic [7:0] rr_data [N];

    stream_mux_nto1_if #(.SEL_W(SEL_W), .W(W)) bus ();

    stream_mux_nto1 #(.SEL_W(SEL_W), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard pop just before the edge, then advance to 1 time unit past it.
    task automatic tick();
        logic [8:0] e;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out", 32'(bus.out_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(e[7:0]));
                chk("out_last", 32'(bus.out_last), 32'(e[8]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int c, input logic [7:0] d, input logic l);
        logic ok;
        int   n;
        bus.in_data[c*8 +: 8] = d;
        bus.in_valid[c]       = 1'b1;
        bus.in_last[c]        = l;
        sb_q.push_back({l, d});
        if (l) pk_sent++;
        #1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 40) begin
            ok = bus.in_ready[c];
            tick();
            n++;
        end
        if (!ok) chk("accept_timeout", 32'(bus.in_ready[c]), 32'd1);
        if (l) bus.in_valid[c] = 1'b0;
    endtask

    initial begin
        int n;
        int exp_ch;
        vectors     = 0;
        miscompares = 0;
        pk_sent     = 0;
        rst           = 1'b1;
        bus.mode      = 1'b0;
        bus.sel       = 2'd0;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.out_ready = 1'b1;

        // Reset values.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_grant",     32'(bus.grant),     32'd0);
        chk("rst_pkt_cnt",   32'(bus.pkt_cnt),   32'd0);
        rst = 1'b0;
        tick();

        // Fixed select, 3-beat packet on channel 2.
        bus.mode = 1'b0;
        bus.sel  = 2'd2;
        send_beat(2, 8'h11, 1'b0);
        chk("t1_grant",     32'(bus.grant),     32'd2);
        chk("t1_latency_v", 32'(bus.out_valid), 32'd1);
        chk("t1_latency_d", 32'(bus.out_data),  32'h11);
        send_beat(2, 8'h22, 1'b0);
        send_beat(2, 8'h33, 1'b1);
        chk("t1_idle_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) tick();
        chk("t1_drained", 32'(sb_q.size()), 32'd0);

        // Round-robin with all channels continuously valid, single-beat packets.
        bus.mode = 1'b1;
        for (int c = 0; c < N; c++) begin
            rr_data[c]              = 8'h80 + 8'(c * 16);
            bus.in_data[c*8 +: 8]   = rr_data[c];
        end
        bus.in_last  = '1;
        bus.in_valid = '1;
        #1;
        for (int p = 0; p < 5; p++) begin
            exp_ch = p % N;
            n = 0;
            while (bus.in_ready == 4'd0 && n < 10) begin
                tick();
                n++;
            end
            chk("rr_grant", 32'(bus.grant), 32'(exp_ch));
            sb_q.push_back({1'b1, rr_data[exp_ch]});
            tick();
            rr_data[exp_ch]                = rr_data[exp_ch] + 8'd1;
            bus.in_data[exp_ch*8 +: 8]     = rr_data[exp_ch];
        end
        pk_sent      = pk_sent + 5;
        bus.in_valid = '0;
        bus.in_last  = '0;
        repeat (3) tick();

        // Backpressure mid-packet on channel 1.
        bus.mode = 1'b0;
        bus.sel  = 2'd1;
        send_beat(1, 8'hA0, 1'b0);
        send_beat(1, 8'hA1, 1'b0);
        bus.out_ready        = 1'b0;
        bus.in_data[8 +: 8]  = 8'hA2;
        #1;
        repeat (3) begin
            chk("bp_in_ready",  32'(bus.in_ready[1]), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid),   32'd1);
            chk("bp_out_data",  32'(bus.out_data),    32'hA1);
            tick();
        end
        bus.out_ready = 1'b1;
        send_beat(1, 8'hA2, 1'b0);
        send_beat(1, 8'hA3, 1'b1);
        repeat (3) tick();
        chk("bp_drained", 32'(sb_q.size()), 32'd0);

        // Lock: grant stays on channel 1 despite sel and channel 0 activity.
        send_beat(1, 8'hB0, 1'b0);
        bus.sel             = 2'd3;
        bus.in_data[0 +: 8] = 8'hEE;
        bus.in_valid[0]     = 1'b1;
        send_beat(1, 8'hB1, 1'b0);
        chk("lock_grant",    32'(bus.grant),       32'd1);
        chk("lock_ready0",   32'(bus.in_ready[0]), 32'd0);
        send_beat(1, 8'hB2, 1'b1);
        chk("lock_grant_end", 32'(bus.grant),      32'd1);
        bus.in_valid[0] = 1'b0;
        bus.sel         = 2'd1;
        repeat (3) tick();

        // Reset mid-packet on channel 2 (round-robin).
        bus.mode = 1'b1;
        send_beat(2, 8'hC0, 1'b0);
        send_beat(2, 8'hC1, 1'b0);
        chk("rm_grant_pre", 32'(bus.grant), 32'd2);
        rst = 1'b1;
        #1;
        chk("rm_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rm_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rm_grant",     32'(bus.grant),     32'd0);
        chk("rm_pkt_cnt",   32'(bus.pkt_cnt),   32'd0);
        sb_q.delete();
        pk_sent      = 0;
        bus.in_valid = '0;
        bus.in_last  = '0;
        tick();
        rst = 1'b0;
        bus.in_data[0 +: 8]  = 8'hD0;
        bus.in_data[16 +: 8] = 8'hD2;
        bus.in_last          = 4'b0101;
        bus.in_valid         = 4'b0101;
        #1;
        n = 0;
        while (bus.in_ready == 4'd0 && n < 10) begin
            tick();
            n++;
        end
        chk("rm_rr_after", 32'(bus.grant), 32'd0);
        sb_q.push_back({1'b1, 8'hD0});
        pk_sent++;
        tick();
        bus.in_valid = '0;
        bus.in_last  = '0;
        repeat (3) tick();

        // Packet counter after three more packets.
        bus.mode = 1'b0;
        bus.sel  = 2'd3;
        send_beat(3, 8'hE1, 1'b1);
        send_beat(3, 8'hE2, 1'b1);
        send_beat(3, 8'hE3, 1'b1);
        repeat (3) tick();
`ifdef STREAM_MUX_PKTCNT_EN
        chk("pkt_cnt", 32'(bus.pkt_cnt), 32'(pk_sent));
`else
        chk("pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
`endif
        chk("sb_leftover", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stream_mux_nto1.md
# stream_mux_nto1

Parametrised N:1 packet-stream multiplexer with a registered output stage and valid/ready handshakes on every port. It is the sequential successor of the combinational 4:1 mux. Each input channel carries a `valid/ready/last` stream. A channel is chosen either by an external select or by round-robin arbitration, and it stays locked until its packet's `last` beat is accepted. The block sits between several packet sources and one shared downstream consumer.

## Interface
Parameters:
- `SEL_W`, default 2: select width; channel count N = 2**SEL_W.
- `W`, default 8: data width per channel.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `mode`  in  1  — 0 = fixed select, 1 = round-robin.
- `sel`  in  SEL_W  — channel index used when `mode`=0.
- `in_data`  in  N*W  — channel c occupies bits [c*W +: W].
- `in_valid`  in  N  — per-channel valid.
- `in_last`  in  N  — per-channel end-of-packet flag.
- `in_ready`  out  N  — per-channel ready.
- `out_data`  out  W  — registered output data.
- `out_valid`  out  1  — registered output valid.
- `out_last`  out  1  — registered output last flag.
- `out_ready`  in  1  — downstream ready.
- `grant`  out  SEL_W  — currently locked or last-locked channel.
- `pkt_cnt`  out  16  — completed-packet counter (see Configuration).

## Operation
- **FSM states:** IDLE and BUSY.
- **Reset values:** state = IDLE, `grant` = 0, round-robin pointer `ptr` = N-1, `out_valid` = 0, `out_data` = 0, `out_last` = 0, `in_ready` = 0, `pkt_cnt` = 0.
- **IDLE, `mode`=0:** if `in_valid[sel]`=1, then `grant` <= `sel` and the FSM goes to BUSY. Otherwise it stays in IDLE.
- **IDLE, `mode`=1:** search channels `ptr`+1 … `ptr`+N, modulo N, and take the first with `in_valid`=1. Then `grant` and `ptr` <= that channel and the FSM goes to BUSY. If no channel is valid, it stays in IDLE.
- **`mode`/`sel` sampling:** both are sampled only in IDLE. Changes while in BUSY are ignored.
- **`in_ready`:** `in_ready[c]` = (state==BUSY) && (c==`grant`) && (!`out_valid` || `out_ready`). All other bits are 0. `in_ready` is combinational from state and `out_ready`.
- **Input beat:** an input beat transfers when `in_valid[grant]` && `in_ready[grant]`. On that edge, `out_data`/`out_last` <= the channel's data and last, and `out_valid` <= 1.
- **Output drain:** when `out_valid` && `out_ready` and no new input beat transfers, `out_valid` <= 0. `out_data` holds its value.
- **End of packet:** an input beat with `in_last`=1 returns the FSM to IDLE on the same edge.
- **Non-grant channels:** held-off channels see `in_ready`=0. Their data is never sampled.
- **Output stability:** while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` must stay stable.

## Timing
- **Arbitration:** takes 1 cycle. The earliest a first beat is accepted is the cycle after `in_valid` is first seen in IDLE.
- **Latency:** input-to-output is 1 cycle. A beat accepted at edge k is presented on `out_*` after edge k.
- **Throughput:** 1 beat per cycle within a packet while `out_ready`=1.
- **Inter-packet gap:** at least 1 idle input cycle per packet boundary, spent in IDLE arbitration. The output may still be draining during it.
- **Single-beat packet:** `in_valid` and `in_last` both 1 on the first beat gives BUSY for 1 cycle, then IDLE.
- **Round-robin wrap:** with `ptr`=N-1, the search starts at channel 0.
- **Simultaneous output drain and new beat:** `out_valid` stays 1 and the data is replaced.
- **Reset mid-packet:** everything returns to the reset values asynchronously. The partial packet is dropped, with no `last` emitted.

## Configuration
- **`STREAM_MUX_PKTCNT_EN` defined:** `pkt_cnt` increments by 1 on each output transfer (`out_valid` && `out_ready`) with `out_last`=1. It wraps from 65535 to 0.
- **`STREAM_MUX_PKTCNT_EN` undefined:** the counter logic is not compiled. `pkt_cnt` is tied to 0.

## Test plan
- **Fixed select, 3-beat packet:** `mode`=0, `sel`=2, `out_ready`=1, channel 2 sends 0x11, 0x22, 0x33 (last on 0x33) → `grant`=2; `out_data` shows 0x11/0x22/0x33 on consecutive cycles with `out_last` only on 0x33; the FSM returns to IDLE.
- **Round-robin fairness:** `mode`=1, all four channels continuously valid with 1-beat packets → grants in order 0, 1, 2, 3, 0.
- **Backpressure:** `out_ready`=0 for 3 cycles mid-packet → `in_ready[grant]`=0 after the held beat; `out_data` stays stable; no beat is lost or duplicated after `out_ready` returns to 1.
- **Lock:** in BUSY on channel 1, toggle `sel` to 3 and assert `in_valid[0]` → `grant` stays 1 until its last beat is accepted; `in_ready[0]` stays 0.
- **Reset mid-packet:** assert `rst` after 2 of 4 beats → immediately `out_valid`=0, `in_ready`=0, `grant`=0; after release, the next round-robin grant is channel 0 if it is valid.
- **Counter (macro defined):** send 3 packets, then preload-wrap test at 65535 → `pkt_cnt`=3; the wrap goes to 0. With the macro undefined, `pkt_cnt`=0 throughout.
